// File: rtl/counter_pkg.sv
// Shared types for the counter strobe path: FSM states, direction codes,
// strobe idle level and a helper that sizes the phase timer.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        GAP,
        FIN
    } state_t;

    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DN      = 1'b1;
    localparam logic STROBE_IDLE = 1'b1;

    // Timer holds max(a,b)-1 at most; keep at least one bit.
    function automatic int tmr_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/step_pulser_if.sv
// Command handshake bundle for step_pulser.
// Ports: CMD_VALID, CMD_DIR, CMD_COUNT (master out), CMD_READY (slave out).
interface step_pulser_if #(
    parameter int CW = 8
);
    logic          CMD_VALID;
    logic          CMD_READY;
    logic          CMD_DIR;
    logic [CW-1:0] CMD_COUNT;

    modport master (
        output CMD_VALID,
        output CMD_DIR,
        output CMD_COUNT,
        input  CMD_READY
    );

    modport slave (
        input  CMD_VALID,
        input  CMD_DIR,
        input  CMD_COUNT,
        output CMD_READY
    );
endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter with zero flag; times the LOW and GAP phases.
// Ports: CLK, CLR (async low), load, load_val in; zero out.
module phase_timer #(
    parameter int TW = 1
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          zero
);
    logic [TW-1:0] cnt;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/step_pulser.sv
// Command-driven INC/DEC strobe generator for the counter_6 chain.
// Ports: CLK, CLR (async low), cmd (valid/ready slave: DIR, COUNT),
//   INC, DEC (idle high, rising edge = step), BUSY, DONE, REMAIN.
// Option: STEP_PULSER_ABORT_EN adds a synchronous ABORT input.
module step_pulser
    import counter_pkg::*;
#(
    parameter int CW      = 8,
    parameter int LOW_CYC = 1,
    parameter int GAP_CYC = 1
) (
    input  logic          CLK,
    input  logic          CLR,
    step_pulser_if.slave  cmd,
`ifdef STEP_PULSER_ABORT_EN
    input  logic          ABORT,
`endif
    output logic          INC,
    output logic          DEC,
    output logic          BUSY,
    output logic          DONE,
    output logic [CW-1:0] REMAIN
);
    localparam int TW = tmr_width(LOW_CYC, GAP_CYC);
    localparam logic [TW-1:0] LOW_LD = TW'(LOW_CYC - 1);
    localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYC - 1);

    state_t        state;
    logic          dir;
    logic          rdy;
    logic          ab_pend;
    logic          abort_in;
    logic          accept;
    logic          t_zero;
    logic          t_load;
    logic [TW-1:0] t_val;

`ifdef STEP_PULSER_ABORT_EN
    assign abort_in = ABORT;
`else
    assign abort_in = 1'b0;
`endif

    assign cmd.CMD_READY = rdy;
    assign accept = cmd.CMD_VALID & rdy;

    phase_timer #(.TW(TW)) u_tmr (
        .CLK      (CLK),
        .CLR      (CLR),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    always_comb begin
        t_load = 1'b0;
        t_val  = LOW_LD;
        unique case (state)
            IDLE: t_load = accept && (cmd.CMD_COUNT != '0);
            LOW: begin
                t_load = t_zero;
                t_val  = GAP_LD;
            end
            GAP: t_load = t_zero && !abort_in && (REMAIN != '0);
            FIN: t_load = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state   <= IDLE;
            dir     <= DIR_UP;
            rdy     <= 1'b1;
            ab_pend <= 1'b0;
            INC     <= STROBE_IDLE;
            DEC     <= STROBE_IDLE;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            REMAIN  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    ab_pend <= 1'b0;
                    if (accept) begin
                        dir    <= cmd.CMD_DIR;
                        REMAIN <= cmd.CMD_COUNT;
                        BUSY   <= 1'b1;
                        rdy    <= 1'b0;
                        if (cmd.CMD_COUNT != '0) begin
                            state <= LOW;
                            if (cmd.CMD_DIR == DIR_DN)
                                DEC <= ~STROBE_IDLE;
                            else
                                INC <= ~STROBE_IDLE;
                        end else begin
                            state <= FIN;
                            DONE  <= 1'b1;
                        end
                    end
                end
                LOW: begin
                    if (t_zero) begin
                        // Rising edge here is the counted step.
                        INC    <= STROBE_IDLE;
                        DEC    <= STROBE_IDLE;
                        REMAIN <= REMAIN - 1'b1;
                        if (ab_pend || abort_in) begin
                            state <= FIN;
                            DONE  <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end else if (abort_in) begin
                        // Finish this low phase; no runt pulse.
                        ab_pend <= 1'b1;
                    end
                end
                GAP: begin
                    if (abort_in || (t_zero && REMAIN == '0)) begin
                        state <= FIN;
                        DONE  <= 1'b1;
                    end else if (t_zero) begin
                        state <= LOW;
                        if (dir == DIR_DN)
                            DEC <= ~STROBE_IDLE;
                        else
                            INC <= ~STROBE_IDLE;
                    end
                end
                FIN: begin
                    state   <= IDLE;
                    DONE    <= 1'b0;
                    BUSY    <= 1'b0;
                    rdy     <= 1'b1;
                    ab_pend <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_step_pulser.sv
// Directed self-checking bench for step_pulser.
// Instance a: LOW_CYC=1 GAP_CYC=1; instance b: LOW_CYC=3 GAP_CYC=2.
module tb_step_pulser;

    logic       clk;
    logic       clr;
    logic       inc_a, dec_a, busy_a, done_a;
    logic       inc_b, dec_b, busy_b, done_b;
    logic [7:0] rem_a, rem_b;
`ifdef STEP_PULSER_ABORT_EN
    logic       abort_a;
    logic       abort_b;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    int q6 = 0;
    int borrow_cnt = 0;
    int both_low = 0;
    logic pinc = 1'b1;
    logic pdec = 1'b1;

    step_pulser_if #(.CW(8)) ia ();
    step_pulser_if #(.CW(8)) ib ();

    step_pulser #(.CW(8), .LOW_CYC(1), .GAP_CYC(1)) dut_a (
        .CLK    (clk),
        .CLR    (clr),
        .cmd    (ia),
`ifdef STEP_PULSER_ABORT_EN
        .ABORT  (abort_a),
`endif
        .INC    (inc_a),
        .DEC    (dec_a),
        .BUSY   (busy_a),
        .DONE   (done_a),
        .REMAIN (rem_a)
    );

    step_pulser #(.CW(8), .LOW_CYC(3), .GAP_CYC(2)) dut_b (
        .CLK    (clk),
        .CLR    (clr),
        .cmd    (ib),
`ifdef STEP_PULSER_ABORT_EN
        .ABORT  (abort_b),
`endif
        .INC    (inc_b),
        .DEC    (dec_b),
        .BUSY   (busy_b),
        .DONE   (done_b),
        .REMAIN (rem_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural mod-6 counter on instance a, plus overlap monitor.
    always @(negedge clk) begin
        if (inc_a && !pinc)
            q6 = (q6 + 1) % 6;
        if (dec_a && !pdec) begin
            if (q6 == 0) begin
                q6 = 5;
                borrow_cnt++;
            end else begin
                q6--;
            end
        end
        pinc = inc_a;
        pdec = dec_a;
        if (!inc_a && !dec_a)
            both_low++;
        if (!inc_b && !dec_b)
            both_low++;
    end

    task automatic send_a(input logic d, input logic [7:0] n);
        int t = 0;
        @(negedge clk);
        while (!ia.CMD_READY && t < 50) begin
            @(negedge clk);
            t++;
        end
        total_cnt++;
        if (ia.CMD_READY !== 1'b1)
            $display("FAIL send_a_ready: got %b want 1", ia.CMD_READY);
        else
            pass_cnt++;
        ia.CMD_VALID = 1'b1;
        ia.CMD_DIR   = d;
        ia.CMD_COUNT = n;
        @(posedge clk);
        #1 ia.CMD_VALID = 1'b0;
    endtask

    task automatic send_b(input logic d, input logic [7:0] n);
        int t = 0;
        @(negedge clk);
        while (!ib.CMD_READY && t < 50) begin
            @(negedge clk);
            t++;
        end
        total_cnt++;
        if (ib.CMD_READY !== 1'b1)
            $display("FAIL send_b_ready: got %b want 1", ib.CMD_READY);
        else
            pass_cnt++;
        ib.CMD_VALID = 1'b1;
        ib.CMD_DIR   = d;
        ib.CMD_COUNT = n;
        @(posedge clk);
        #1 ib.CMD_VALID = 1'b0;
    endtask

    task automatic test_reset;
        clr = 1'b0;
        #12;
        total_cnt++;
        if ({inc_a, dec_a, busy_a, done_a} !== 4'b1100)
            $display("FAIL rst_a_flags: got %b want 1100",
                     {inc_a, dec_a, busy_a, done_a});
        else
            pass_cnt++;
        total_cnt++;
        if (rem_a !== 8'd0)
            $display("FAIL rst_a_remain: got %0d want 0", rem_a);
        else
            pass_cnt++;
        total_cnt++;
        if (ia.CMD_READY !== 1'b1)
            $display("FAIL rst_a_ready: got %b want 1", ia.CMD_READY);
        else
            pass_cnt++;
        total_cnt++;
        if ({inc_b, dec_b, busy_b, done_b, ib.CMD_READY} !== 5'b11001)
            $display("FAIL rst_b_flags: got %b want 11001",
                     {inc_b, dec_b, busy_b, done_b, ib.CMD_READY});
        else
            pass_cnt++;
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_up3;
        int rises[$];
        int done_k = 0;
        int dec_low = 0;
        logic p = 1'b1;
        q6 = 0;
        send_a(1'b0, 8'd3);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                total_cnt++;
                if ({busy_a, rem_a} !== {1'b1, 8'd3})
                    $display("FAIL up3_start: busy %b rem %0d want 1 3",
                             busy_a, rem_a);
                else
                    pass_cnt++;
            end
            if (inc_a && !p)
                rises.push_back(k);
            p = inc_a;
            if (!dec_a)
                dec_low++;
            if (done_a) begin
                done_k = k;
                break;
            end
        end
        total_cnt++;
        if (done_k !== 7)
            $display("FAIL up3_done: got cycle %0d want 7", done_k);
        else
            pass_cnt++;
        total_cnt++;
        if (rises.size() != 3 || rises[0] != 2 ||
            rises[1] != 4 || rises[2] != 6)
            $display("FAIL up3_edges: got %0d edges want 3 at 2,4,6",
                     rises.size());
        else
            pass_cnt++;
        total_cnt++;
        if (dec_low !== 0)
            $display("FAIL up3_dec: got %0d low cycles want 0", dec_low);
        else
            pass_cnt++;
        total_cnt++;
        if (q6 !== 3)
            $display("FAIL up3_q: got %0d want 3", q6);
        else
            pass_cnt++;
    endtask

    task automatic test_down1;
        int done_k = 0;
        int inc_low = 0;
        q6 = 0;
        borrow_cnt = 0;
        send_a(1'b1, 8'd1);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!inc_a)
                inc_low++;
            if (done_a) begin
                done_k = k;
                break;
            end
        end
        total_cnt++;
        if (done_k !== 3)
            $display("FAIL dn1_done: got cycle %0d want 3", done_k);
        else
            pass_cnt++;
        total_cnt++;
        if (q6 !== 5 || borrow_cnt !== 1)
            $display("FAIL dn1_q: got q %0d borrow %0d want 5 1",
                     q6, borrow_cnt);
        else
            pass_cnt++;
        total_cnt++;
        if (inc_low !== 0)
            $display("FAIL dn1_inc: got %0d low cycles want 0", inc_low);
        else
            pass_cnt++;
    endtask

    task automatic test_zero;
        send_a(1'b0, 8'd0);
        @(negedge clk);
        total_cnt++;
        if ({busy_a, done_a, ia.CMD_READY, inc_a, dec_a} !== 5'b11011)
            $display("FAIL zero_fin: got %b want 11011",
                     {busy_a, done_a, ia.CMD_READY, inc_a, dec_a});
        else
            pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({busy_a, done_a, ia.CMD_READY, inc_a, dec_a} !== 5'b00111)
            $display("FAIL zero_idle: got %b want 00111",
                     {busy_a, done_a, ia.CMD_READY, inc_a, dec_a});
        else
            pass_cnt++;
    endtask

    task automatic test_timing;
        int rises[$];
        int rems[$];
        int runs[$];
        int run = 0;
        int done_k = 0;
        int dec_low = 0;
        logic p = 1'b1;
        send_b(1'b0, 8'd4);
        // Held valid while busy must not start a new command.
        ib.CMD_VALID = 1'b1;
        ib.CMD_COUNT = 8'd9;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 15)
                ib.CMD_VALID = 1'b0;
            if (k == 1) begin
                total_cnt++;
                if (rem_b !== 8'd4)
                    $display("FAIL tim_rem0: got %0d want 4", rem_b);
                else
                    pass_cnt++;
            end
            if (!inc_b) begin
                run++;
            end else if (run > 0) begin
                runs.push_back(run);
                run = 0;
            end
            if (inc_b && !p) begin
                rises.push_back(k);
                rems.push_back(int'(rem_b));
            end
            p = inc_b;
            if (!dec_b)
                dec_low++;
            if (done_b) begin
                done_k = k;
                break;
            end
        end
        total_cnt++;
        if (done_k !== 21)
            $display("FAIL tim_done: got cycle %0d want 21", done_k);
        else
            pass_cnt++;
        total_cnt++;
        if (runs.size() != 4 || runs[0] != 3 || runs[1] != 3 ||
            runs[2] != 3 || runs[3] != 3)
            $display("FAIL tim_low: got %0d runs first %0d want 4 of 3",
                     runs.size(), runs[0]);
        else
            pass_cnt++;
        total_cnt++;
        if (rises.size() != 4 || rises[0] != 4 || rises[1] != 9 ||
            rises[2] != 14 || rises[3] != 19)
            $display("FAIL tim_edges: got %0d edges want 4 at 4,9,14,19",
                     rises.size());
        else
            pass_cnt++;
        total_cnt++;
        if (rems.size() != 4 || rems[0] != 3 || rems[1] != 2 ||
            rems[2] != 1 || rems[3] != 0)
            $display("FAIL tim_remain: got %0d,%0d,%0d,%0d want 3,2,1,0",
                     rems[0], rems[1], rems[2], rems[3]);
        else
            pass_cnt++;
        total_cnt++;
        if (dec_low !== 0)
            $display("FAIL tim_dec: got %0d low cycles want 0", dec_low);
        else
            pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({busy_b, ib.CMD_READY, inc_b} !== 3'b011)
            $display("FAIL tim_idle: got %b want 011",
                     {busy_b, ib.CMD_READY, inc_b});
        else
            pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int done_k = 0;
        int rises = 0;
        logic p = 1'b1;
        send_a(1'b0, 8'd5);
        for (int k = 1; k <= 3; k++)
            @(negedge clk);
        total_cnt++;
        if (inc_a !== 1'b0)
            $display("FAIL rmid_low: got %b want 0", inc_a);
        else
            pass_cnt++;
        clr = 1'b0;
        #1;
        total_cnt++;
        if ({inc_a, dec_a, busy_a, ia.CMD_READY} !== 4'b1101)
            $display("FAIL rmid_flags: got %b want 1101",
                     {inc_a, dec_a, busy_a, ia.CMD_READY});
        else
            pass_cnt++;
        total_cnt++;
        if (rem_a !== 8'd0)
            $display("FAIL rmid_remain: got %0d want 0", rem_a);
        else
            pass_cnt++;
        @(negedge clk);
        clr = 1'b1;
        send_a(1'b1, 8'd2);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (dec_a && !p)
                rises++;
            p = dec_a;
            if (done_a) begin
                done_k = k;
                break;
            end
        end
        total_cnt++;
        if (done_k !== 5 || rises !== 2)
            $display("FAIL rmid_after: got done %0d edges %0d want 5 2",
                     done_k, rises);
        else
            pass_cnt++;
    endtask

`ifdef STEP_PULSER_ABORT_EN
    task automatic test_abort;
        int rises = 0;
        logic p = 1'b1;
        send_a(1'b0, 8'd10);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (inc_a && !p)
                rises++;
            p = inc_a;
        end
        total_cnt++;
        if (rises !== 3 || rem_a !== 8'd7)
            $display("FAIL abort_pre: got edges %0d rem %0d want 3 7",
                     rises, rem_a);
        else
            pass_cnt++;
        abort_a = 1'b1;
        @(posedge clk);
        #1 abort_a = 1'b0;
        @(negedge clk);
        if (inc_a && !p)
            rises++;
        p = inc_a;
        total_cnt++;
        if ({done_a, busy_a, inc_a} !== 3'b111 || rem_a !== 8'd7)
            $display("FAIL abort_fin: got %b rem %0d want 111 7",
                     {done_a, busy_a, inc_a}, rem_a);
        else
            pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!inc_a)
                rises++;
        end
        total_cnt++;
        if (rises !== 3 || busy_a !== 1'b0 || ia.CMD_READY !== 1'b1)
            $display("FAIL abort_idle: got edges %0d busy %b want 3 0",
                     rises, busy_a);
        else
            pass_cnt++;
    endtask
`endif

    task automatic test_no_overlap;
        total_cnt++;
        if (both_low !== 0)
            $display("FAIL no_overlap: got %0d cycles want 0", both_low);
        else
            pass_cnt++;
    endtask

    initial begin
        ia.CMD_VALID = 1'b0;
        ia.CMD_DIR   = 1'b0;
        ia.CMD_COUNT = 8'd0;
        ib.CMD_VALID = 1'b0;
        ib.CMD_DIR   = 1'b0;
        ib.CMD_COUNT = 8'd0;
`ifdef STEP_PULSER_ABORT_EN
        abort_a = 1'b0;
        abort_b = 1'b0;
`endif
        test_reset();
        test_up3();
        test_down1();
        test_zero();
        test_timing();
        test_reset_mid();
`ifdef STEP_PULSER_ABORT_EN
        test_abort();
`endif
        test_no_overlap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/step_pulser.md
Name: step_pulser

Overview:
- Command-driven strobe generator that drives the INC/DEC inputs of the counter_6 chain, or of any counter that uses the same edge protocol.
- Accepts a direction and a step count over a valid/ready handshake, then emits that many clean, non-overlapping strobe pulses on INC or DEC.
- Sits between the timer control logic and the first counter digit. It replaces ad-hoc glitch-prone strobes with clock-timed, protocol-correct pulses.

Parameters:
- CW, 8, width of the step count.
- LOW_CYC, 1, clock cycles a strobe is held low per step (must be >=1).
- GAP_CYC, 1, clock cycles both strobes stay high after each rising edge before the next step (must be >=1).

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  reset, asynchronous, active-low.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  block accepts a command this cycle.
- CMD_DIR  in  1  step direction: 0 = up (INC), 1 = down (DEC).
- CMD_COUNT  in  CW  number of steps to emit (0 is legal).
- INC  out  1  up strobe; idle high; each rising edge is one count step.
- DEC  out  1  down strobe; idle high; each rising edge is one count step.
- BUSY  out  1  command in progress.
- DONE  out  1  one-cycle pulse when a command completes.
- REMAIN  out  CW  steps still to be emitted for the current command.

Behaviour:
- Reset (CLR low, asynchronous):
  - State IDLE; INC=1, DEC=1, BUSY=0, DONE=0, REMAIN=0, CMD_READY=1.
  - Internal phase timer cleared.
  - Reset mid-pulse forces INC/DEC high immediately. The downstream counter sees that as one rising edge; this is accepted.
- All outputs are registered. Strobes never glitch.
- Invariant: INC and DEC are never both low in any cycle.
- Handshake:
  - CMD_READY=1 only in IDLE.
  - A transfer occurs on a clock edge with CMD_VALID & CMD_READY; DIR and COUNT are latched on that edge.
  - CMD_VALID is ignored while not ready; no queueing.
- FSM states: IDLE, LOW, GAP, FIN.
  - IDLE: on transfer with COUNT>0, go to LOW. The selected strobe goes low in the first cycle after the edge. REMAIN=COUNT, BUSY=1.
  - IDLE: on transfer with COUNT=0, go to FIN. No strobe activity, BUSY=1 for one cycle.
  - LOW: selected strobe low for exactly LOW_CYC cycles. Then go to GAP; the strobe returns high (this is the counted rising edge) and REMAIN decrements by 1 on the same edge.
  - GAP: both strobes high for GAP_CYC cycles. Then go to LOW if REMAIN>0, else to FIN.
  - FIN: DONE=1 and BUSY=1 for one cycle, then IDLE with DONE=0, BUSY=0, CMD_READY=1.
- Timing:
  - Step period is LOW_CYC+GAP_CYC cycles.
  - For COUNT=N>0, latency from the accept edge to DONE is N*(LOW_CYC+GAP_CYC)+1 cycles.
- Width rules:
  - COUNT = 2^CW-1 is legal; REMAIN does not wrap.
  - The phase timer is sized to max(LOW_CYC, GAP_CYC).
- CARRY/BORROW of the downstream counter are not inputs to this block. Cascading is the counter chain's job.

Optional Feature:
- Macro: STEP_PULSER_ABORT_EN.
- Defined:
  - Adds input ABORT (1, active-high, synchronous).
  - ABORT in LOW completes the current low phase normally, so no runt pulse and the step still counts. The block then goes to FIN.
  - ABORT in GAP goes to FIN on the next edge.
  - In both cases REMAIN holds the unsent count, and DONE pulses as usual.
  - ABORT in IDLE or FIN has no effect.
- Undefined: no ABORT port; every accepted command runs to completion.

Decomposition:
- Shared package counter_pkg holds:
  - the FSM state enum (IDLE, LOW, GAP, FIN);
  - direction constants DIR_UP=0, DIR_DN=1;
  - strobe idle level STROBE_IDLE=1.
- One natural sub-module, phase_timer: a loadable down-counter with zero flag that times the LOW and GAP phases.
- The FSM, count register and strobe registers live in step_pulser.

Test Plan:
- Reset, then COUNT=3, DIR=0, LOW_CYC=1, GAP_CYC=1 -> exactly 3 INC rising edges 2 cycles apart; DEC constantly 1; DONE 7 cycles after accept; attached counter_6 reads Q=3.
- From Q=0, COUNT=1, DIR=1 -> one DEC edge; counter_6 Q=5 and BORROW pulses; INC stays 1 throughout.
- COUNT=0 -> no strobe edges; BUSY high 1 cycle; DONE pulses the cycle after accept; CMD_READY back high next cycle.
- LOW_CYC=3, GAP_CYC=2, COUNT=4, DIR=0 -> INC low runs of exactly 3 cycles, high gaps of 2; REMAIN steps 4,3,2,1,0; DONE at cycle 21; CMD_VALID held high during BUSY is not accepted.
- CLR low during the second LOW phase of COUNT=5 -> INC and DEC high immediately; BUSY=0, REMAIN=0, CMD_READY=1 while CLR low; a new command is accepted after release.
- With STEP_PULSER_ABORT_EN, COUNT=10, ABORT in GAP after the 3rd edge -> no further edges; REMAIN=7; DONE pulses; INC/DEC never both low in any test (checked by assertion).
